// File: rtl/ftq_rdport_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | ftq_rdport_arb_pkg                                                      |
// | Shared FTQ read-port types and sizing constants for the backend.        |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package ftq_rdport_arb_pkg;

  localparam int BRU_NUM   = 2;
  localparam int FTQ_IDX_W = 5;
  localparam int FTQ_XLEN  = 64;

  typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;

  typedef struct packed {
    logic [FTQ_XLEN-1:0] startAddr;
    logic [FTQ_XLEN-1:0] nextAddr;
  } ftqRdRsp_t;

  // Which requester owns FTQ read port 0 in the current cycle.
  typedef enum logic [1:0] {
    P0_NONE = 2'd0,
    P0_ROB  = 2'd1,
    P0_BRU  = 2'd2
  } port0_owner_e;

endpackage

`default_nettype wire

// File: rtl/ftq_rdport_arb_port0_prio.sv
// +--------------------------------------------------------------------------+
// | ftq_port0_prio                                                          |
// | ROB-first arbiter for shared port 0 with a BRU0 starvation guard.       |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module ftq_port0_prio
  import ftq_rdport_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_squash_vld,
  input  logic         i_rob_req,
  input  logic         i_bru_req,
  output logic         o_rob_gnt,
  output logic         o_bru_gnt,
  output port0_owner_e o_owner,
  output logic [1:0]   o_starve_cnt
);

  localparam logic [1:0] c_starve_max = 2'(STARVE_MAX);

  logic [1:0] starve_cnt_q;
  logic [1:0] starve_cnt_d;
  logic       w_bru_ok;
  logic       w_bru_win;
  logic       w_rob_win;

  always_comb begin
    w_bru_ok     = i_bru_req & ~i_squash_vld;
    w_bru_win    = rst & w_bru_ok & (~i_rob_req | (starve_cnt_q == c_starve_max));
    w_rob_win    = rst & i_rob_req & ~w_bru_win;
    starve_cnt_d = starve_cnt_q;
    // Squash freezes the count so a forced BRU0 win is not lost to the kill.
    if (i_squash_vld) begin
      starve_cnt_d = starve_cnt_q;
    end else if (!i_bru_req || w_bru_win) begin
      starve_cnt_d = 2'd0;
    end else if (w_rob_win && (starve_cnt_q != c_starve_max)) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 2'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    o_owner = P0_NONE;
    if (w_rob_win) begin
      o_owner = P0_ROB;
    end else if (w_bru_win) begin
      o_owner = P0_BRU;
    end
  end

  assign o_rob_gnt    = w_rob_win;
  assign o_bru_gnt    = w_bru_win;
  assign o_starve_cnt = starve_cnt_q;

endmodule

`default_nettype wire

// File: rtl/ftq_rdport_arb.sv
// +--------------------------------------------------------------------------+
// | ftq_rdport_arb                                                          |
// | Arbitrates FTQ read ports between ROB commit and BRU pipes.             |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module ftq_rdport_arb
  import ftq_rdport_arb_pkg::*;
#(
  parameter int NUM_BRU    = BRU_NUM,
  parameter int IDX_W      = FTQ_IDX_W,
  parameter int XLEN       = FTQ_XLEN,
  parameter int STARVE_MAX = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_squash_vld,
  input  logic                           i_rob_req,
  input  logic [IDX_W-1:0]               i_rob_ftqIdx,
  output logic                           o_rob_gnt,
  output logic                           o_rob_rsp_vld,
  output logic [XLEN-1:0]                o_rob_startAddr,
  input  logic [NUM_BRU-1:0]             i_bru_req,
  input  logic [NUM_BRU-1:0][IDX_W-1:0]  i_bru_ftqIdx,
  output logic [NUM_BRU-1:0]             o_bru_gnt,
  output logic [NUM_BRU-1:0]             o_bru_rsp_vld,
  output logic [NUM_BRU-1:0][XLEN-1:0]   o_bru_startAddr,
  output logic [NUM_BRU-1:0][XLEN-1:0]   o_bru_nextAddr,
  output logic [NUM_BRU-1:0][IDX_W-1:0]  o_read_ftqIdx,
  input  logic [NUM_BRU-1:0][XLEN-1:0]   i_read_ftqStartAddr,
  input  logic [NUM_BRU-1:0][XLEN-1:0]   i_read_ftqNextAddr
);

  logic [NUM_BRU-1:0]           w_bru_gnt;
  logic                         w_rob_gnt;
  port0_owner_e                 w_p0_owner;
  logic [1:0]                   w_starve_cnt;

  logic                         rob_rsp_vld_q;
  logic                         rob_rsp_vld_d;
  logic [XLEN-1:0]              rob_start_q;
  logic [XLEN-1:0]              rob_start_d;
  logic [NUM_BRU-1:0]           bru_rsp_vld_q;
  logic [NUM_BRU-1:0]           bru_rsp_vld_d;
  logic [NUM_BRU-1:0][XLEN-1:0] bru_start_q;
  logic [NUM_BRU-1:0][XLEN-1:0] bru_start_d;
  logic [NUM_BRU-1:0][XLEN-1:0] bru_next_q;
  logic [NUM_BRU-1:0][XLEN-1:0] bru_next_d;

  ftq_port0_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_port0 (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_rob_req    (i_rob_req),
    .i_bru_req    (i_bru_req[0]),
    .o_rob_gnt    (w_rob_gnt),
    .o_bru_gnt    (w_bru_gnt[0]),
    .o_owner      (w_p0_owner),
    .o_starve_cnt (w_starve_cnt)
  );

  always_comb begin
    o_read_ftqIdx[0] = '0;
    case (w_p0_owner)
      P0_ROB:  o_read_ftqIdx[0] = i_rob_ftqIdx;
      P0_BRU:  o_read_ftqIdx[0] = i_bru_ftqIdx[0];
      default: o_read_ftqIdx[0] = '0;
    endcase
  end

  // Dedicated ports: only the squash mask stands between request and grant.
  for (genvar k = 1; k < NUM_BRU; k++) begin : g_bru_port
    assign w_bru_gnt[k]     = rst & i_bru_req[k] & ~i_squash_vld;
    assign o_read_ftqIdx[k] = w_bru_gnt[k] ? i_bru_ftqIdx[k] : '0;
  end

  always_comb begin
    rob_rsp_vld_d = w_rob_gnt;
    rob_start_d   = w_rob_gnt ? i_read_ftqStartAddr[0] : rob_start_q;
    bru_rsp_vld_d = w_bru_gnt;
    bru_start_d   = bru_start_q;
    bru_next_d    = bru_next_q;
    for (int k = 0; k < NUM_BRU; k++) begin
      if (w_bru_gnt[k]) begin
        bru_start_d[k] = i_read_ftqStartAddr[k];
        bru_next_d[k]  = i_read_ftqNextAddr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_rsp_vld_q <= 1'b0;
      rob_start_q   <= '0;
      bru_rsp_vld_q <= '0;
      bru_start_q   <= '0;
      bru_next_q    <= '0;
    end else begin
      rob_rsp_vld_q <= rob_rsp_vld_d;
      rob_start_q   <= rob_start_d;
      bru_rsp_vld_q <= bru_rsp_vld_d;
      bru_start_q   <= bru_start_d;
      bru_next_q    <= bru_next_d;
    end
  end

  assign o_rob_gnt       = w_rob_gnt;
  assign o_bru_gnt       = w_bru_gnt;
  assign o_rob_rsp_vld   = rob_rsp_vld_q;
  assign o_rob_startAddr = rob_start_q;
  assign o_bru_rsp_vld   = bru_rsp_vld_q;
  assign o_bru_startAddr = bru_start_q;
  assign o_bru_nextAddr  = bru_next_q;

  logic w_unused;
  assign w_unused = ^w_starve_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ftq_rdport_arb.sv
// +--------------------------------------------------------------------------+
// | tb_ftq_rdport_arb                                                       |
// | Directed self-checking bench for ftq_rdport_arb.                        |
// | Rev 1.0                                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ftq_rdport_arb;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 squash;
  logic                 rob_req;
  logic [4:0]           rob_idx;
  logic                 rob_gnt;
  logic                 rob_rsp_vld;
  logic [63:0]          rob_start;
  logic [1:0]           bru_req;
  logic [1:0][4:0]      bru_idx;
  logic [1:0]           bru_gnt;
  logic [1:0]           bru_rsp_vld;
  logic [1:0][63:0]     bru_start;
  logic [1:0][63:0]     bru_next;
  logic [1:0][4:0]      read_idx;
  logic [1:0][63:0]     rd_start;
  logic [1:0][63:0]     rd_next;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ftq_rdport_arb dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_squash_vld        (squash),
    .i_rob_req           (rob_req),
    .i_rob_ftqIdx        (rob_idx),
    .o_rob_gnt           (rob_gnt),
    .o_rob_rsp_vld       (rob_rsp_vld),
    .o_rob_startAddr     (rob_start),
    .i_bru_req           (bru_req),
    .i_bru_ftqIdx        (bru_idx),
    .o_bru_gnt           (bru_gnt),
    .o_bru_rsp_vld       (bru_rsp_vld),
    .o_bru_startAddr     (bru_start),
    .o_bru_nextAddr      (bru_next),
    .o_read_ftqIdx       (read_idx),
    .i_read_ftqStartAddr (rd_start),
    .i_read_ftqNextAddr  (rd_next)
  );

  task automatic test_reset;
    rst = 1'b0; squash = 1'b0;
    rob_req = 1'b1; rob_idx = 5'd4;
    bru_req = 2'b11; bru_idx[0] = 5'd5; bru_idx[1] = 5'd6;
    rd_start = '0; rd_next = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rob_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_rob_gnt got %b exp 0", rob_gnt); end
    n_checks++; if (bru_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_bru_gnt got %b exp 00", bru_gnt); end
    n_checks++; if (rob_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rob_rsp got %b exp 0", rob_rsp_vld); end
    n_checks++; if (bru_rsp_vld !== 2'b00) begin n_fail++; $display("FAIL reset_bru_rsp got %b exp 00", bru_rsp_vld); end
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    n_checks++; if (rob_gnt !== 1'b1) begin n_fail++; $display("FAIL release_rob_gnt got %b exp 1", rob_gnt); end
    n_checks++; if (bru_gnt !== 2'b10) begin n_fail++; $display("FAIL release_bru_gnt got %b exp 10", bru_gnt); end
    n_checks++; if (read_idx[1] !== 5'd6) begin n_fail++; $display("FAIL release_idx1 got %0d exp 6", read_idx[1]); end
    n_checks++; if (read_idx[0] !== 5'd4) begin n_fail++; $display("FAIL release_idx0 got %0d exp 4", read_idx[0]); end
    @(posedge clk); #1;
    n_checks++; if (rob_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL release_rob_rsp got %b exp 1", rob_rsp_vld); end
    n_checks++; if (bru_rsp_vld !== 2'b10) begin n_fail++; $display("FAIL release_bru_rsp got %b exp 10", bru_rsp_vld); end
    rob_req = 1'b0; bru_req = 2'b00;
  endtask

  task automatic test_rob_only;
    @(posedge clk); #1;
    rob_req = 1'b1; rob_idx = 5'd7; rd_start[0] = 64'h8000_0040;
    #4;
    n_checks++; if (read_idx[0] !== 5'd7) begin n_fail++; $display("FAIL rob_only_idx got %0d exp 7", read_idx[0]); end
    n_checks++; if (rob_gnt !== 1'b1) begin n_fail++; $display("FAIL rob_only_gnt got %b exp 1", rob_gnt); end
    n_checks++; if (bru_gnt !== 2'b00) begin n_fail++; $display("FAIL rob_only_bru_gnt got %b exp 00", bru_gnt); end
    @(posedge clk); #1;
    n_checks++; if (rob_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL rob_only_rsp got %b exp 1", rob_rsp_vld); end
    n_checks++; if (rob_start !== 64'h8000_0040) begin n_fail++; $display("FAIL rob_only_data got %h exp 8000_0040", rob_start); end
    rob_req = 1'b0; rd_start[0] = 64'hdead;
    @(posedge clk); #1;
    n_checks++; if (rob_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rob_only_rsp_drop got %b exp 0", rob_rsp_vld); end
    n_checks++; if (rob_start !== 64'h8000_0040) begin n_fail++; $display("FAIL rob_only_hold got %h exp 8000_0040", rob_start); end
  endtask

  task automatic test_contest;
    logic       bw;
    logic [1:0] exp_cnt;
    @(posedge clk); #1;
    rob_req = 1'b1; rob_idx = 5'd1; bru_req = 2'b01; bru_idx[0] = 5'd2;
    rd_start[0] = 64'hA0; rd_next[0] = 64'hB0;
    for (int i = 0; i < 8; i++) begin
      bw      = ((i % 4) == 3);
      exp_cnt = 2'((i + 1) % 4);
      #4;
      n_checks++; if (rob_gnt !== !bw) begin n_fail++; $display("FAIL contest_rob_gnt[%0d] got %b exp %b", i, rob_gnt, !bw); end
      n_checks++; if (bru_gnt[0] !== bw) begin n_fail++; $display("FAIL contest_bru0_gnt[%0d] got %b exp %b", i, bru_gnt[0], bw); end
      n_checks++; if (read_idx[0] !== (bw ? 5'd2 : 5'd1)) begin n_fail++; $display("FAIL contest_idx[%0d] got %0d exp %0d", i, read_idx[0], bw ? 2 : 1); end
      @(posedge clk); #1;
      n_checks++; if (dut.u_port0.starve_cnt_q !== exp_cnt) begin n_fail++; $display("FAIL contest_starve[%0d] got %0d exp %0d", i, dut.u_port0.starve_cnt_q, exp_cnt); end
      n_checks++; if (bru_rsp_vld[0] !== bw) begin n_fail++; $display("FAIL contest_bru0_rsp[%0d] got %b exp %b", i, bru_rsp_vld[0], bw); end
    end
    n_checks++; if (bru_start[0] !== 64'hA0) begin n_fail++; $display("FAIL contest_bru0_start got %h exp a0", bru_start[0]); end
    n_checks++; if (bru_next[0] !== 64'hB0) begin n_fail++; $display("FAIL contest_bru0_next got %h exp b0", bru_next[0]); end
    rob_req = 1'b0; bru_req = 2'b00;
  endtask

  task automatic test_squash_bru1;
    @(posedge clk); #1;
    bru_req = 2'b10; bru_idx[1] = 5'd3; squash = 1'b1;
    rd_start[1] = 64'h1111; rd_next[1] = 64'h2222;
    #4;
    n_checks++; if (bru_gnt[1] !== 1'b0) begin n_fail++; $display("FAIL sq_bru1_gnt got %b exp 0", bru_gnt[1]); end
    n_checks++; if (read_idx[1] !== 5'd0) begin n_fail++; $display("FAIL sq_bru1_idx got %0d exp 0", read_idx[1]); end
    @(posedge clk); #1;
    n_checks++; if (bru_rsp_vld[1] !== 1'b0) begin n_fail++; $display("FAIL sq_bru1_rsp got %b exp 0", bru_rsp_vld[1]); end
    squash = 1'b0;
    #4;
    n_checks++; if (bru_gnt[1] !== 1'b1) begin n_fail++; $display("FAIL sq_bru1_regnt got %b exp 1", bru_gnt[1]); end
    n_checks++; if (read_idx[1] !== 5'd3) begin n_fail++; $display("FAIL sq_bru1_reidx got %0d exp 3", read_idx[1]); end
    @(posedge clk); #1;
    bru_req = 2'b00; squash = 1'b1;
    #1;
    n_checks++; if (bru_rsp_vld[1] !== 1'b1) begin n_fail++; $display("FAIL sq_bru1_late_rsp got %b exp 1", bru_rsp_vld[1]); end
    n_checks++; if (bru_start[1] !== 64'h1111) begin n_fail++; $display("FAIL sq_bru1_start got %h exp 1111", bru_start[1]); end
    n_checks++; if (bru_next[1] !== 64'h2222) begin n_fail++; $display("FAIL sq_bru1_next got %h exp 2222", bru_next[1]); end
    squash = 1'b0;
  endtask

  task automatic test_squash_starve;
    @(posedge clk); #1;
    rob_req = 1'b1; rob_idx = 5'd9; bru_req = 2'b01; bru_idx[0] = 5'd10;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dut.u_port0.starve_cnt_q !== 2'd3) begin n_fail++; $display("FAIL ss_cnt_pre got %0d exp 3", dut.u_port0.starve_cnt_q); end
    squash = 1'b1;
    #3;
    n_checks++; if (rob_gnt !== 1'b1) begin n_fail++; $display("FAIL ss_rob_gnt got %b exp 1", rob_gnt); end
    n_checks++; if (bru_gnt[0] !== 1'b0) begin n_fail++; $display("FAIL ss_bru0_gnt got %b exp 0", bru_gnt[0]); end
    n_checks++; if (read_idx[0] !== 5'd9) begin n_fail++; $display("FAIL ss_idx got %0d exp 9", read_idx[0]); end
    @(posedge clk); #1;
    n_checks++; if (dut.u_port0.starve_cnt_q !== 2'd3) begin n_fail++; $display("FAIL ss_cnt_hold got %0d exp 3", dut.u_port0.starve_cnt_q); end
    n_checks++; if (bru_rsp_vld[0] !== 1'b0) begin n_fail++; $display("FAIL ss_bru0_rsp got %b exp 0", bru_rsp_vld[0]); end
    squash = 1'b0;
    #3;
    n_checks++; if (bru_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL ss_bru0_win got %b exp 1", bru_gnt[0]); end
    n_checks++; if (rob_gnt !== 1'b0) begin n_fail++; $display("FAIL ss_rob_lose got %b exp 0", rob_gnt); end
    @(posedge clk); #1;
    n_checks++; if (dut.u_port0.starve_cnt_q !== 2'd0) begin n_fail++; $display("FAIL ss_cnt_clr got %0d exp 0", dut.u_port0.starve_cnt_q); end
    rob_req = 1'b0; bru_req = 2'b00;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rob_req = 1'b1; rob_idx = 5'd7; rd_start[0] = 64'h8000_0040;
    bru_req = 2'b10; rd_start[1] = 64'h3333;
    @(posedge clk); #1;
    rob_req = 1'b0; bru_req = 2'b00;
    n_checks++; if (rob_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL mid_rob_rsp_pre got %b exp 1", rob_rsp_vld); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (rob_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rob_rsp got %b exp 0", rob_rsp_vld); end
    n_checks++; if (bru_rsp_vld !== 2'b00) begin n_fail++; $display("FAIL mid_bru_rsp got %b exp 00", bru_rsp_vld); end
    n_checks++; if (rob_start !== 64'h0) begin n_fail++; $display("FAIL mid_rob_data got %h exp 0", rob_start); end
    n_checks++; if (bru_start[1] !== 64'h0) begin n_fail++; $display("FAIL mid_bru1_data got %h exp 0", bru_start[1]); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rob_only();
    test_contest();
    test_squash_bru1();
    test_squash_starve();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
